// File: rtl/dcr_host_ctrl_if.sv
// rtl/dcr_host_ctrl_if.sv - host command/response streams plus DCR write and launch handshake
interface dcr_host_ctrl_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready;
    logic       device_control_write_enable;
    logic [7:0] device_control_data;
    logic [7:0] thread_count;
    logic       start;
    logic       done;

    modport master (
        output cmd_valid, cmd_data, rsp_ready, thread_count, done,
        input  cmd_ready, rsp_valid, rsp_data, device_control_write_enable,
               device_control_data, start
    );

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready, thread_count, done,
        output cmd_ready, rsp_valid, rsp_data, device_control_write_enable,
               device_control_data, start
    );
endinterface

// File: rtl/dcr_host_ctrl.sv
// rtl/dcr_host_ctrl.sv - byte command sequencer for DCR writes, readback and kernel launch
module dcr_host_ctrl #(
    parameter int TIMEOUT = 1024
) (
    input logic           clk,
    input logic           reset,
    dcr_host_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, GET_ARG, WRITE, LAUNCH, RESP} state_t;

    state_t          state, state_nx;
    logic [7:0]      rsp_q, rsp_nx;
    logic [7:0]      dcd_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_inc;
    logic            cmd_rdy;
    logic            accept;
    logic            timed_out;

    assign accept    = bus.cmd_valid && cmd_rdy;
    assign cnt_inc   = cnt_q + 1'b1;
    // Fires on the TIMEOUT-th LAUNCH cycle, so start is high for exactly TIMEOUT cycles
    assign timed_out = (cnt_inc == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rsp_nx   = rsp_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_data)
                        8'h01: state_nx = GET_ARG;
                        8'h02: begin
                            state_nx = RESP;
                            rsp_nx   = bus.thread_count;
                        end
                        8'h03: begin
                            if (bus.thread_count == 8'h00) begin
                                state_nx = RESP;
                                rsp_nx   = 8'hE1;
                            end else begin
                                state_nx = LAUNCH;
                            end
                        end
                        default: begin
                            state_nx = RESP;
                            rsp_nx   = 8'hEF;
                        end
                    endcase
                end
            end
            GET_ARG: begin
                if (accept) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                state_nx = RESP;
                rsp_nx   = 8'h00;
            end
            LAUNCH: begin
                // done takes priority over a timeout landing in the same cycle
                if (bus.done) begin
                    state_nx = RESP;
                    rsp_nx   = 8'h00;
                end else if (timed_out) begin
                    state_nx = RESP;
                    rsp_nx   = 8'hE2;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy                         = (state == IDLE) || (state == GET_ARG);
        bus.rsp_valid                   = (state == RESP);
        bus.device_control_write_enable = (state == WRITE);
        bus.start                       = (state == LAUNCH);
    end

    assign bus.cmd_ready           = cmd_rdy;
    assign bus.rsp_data            = rsp_q;
    assign bus.device_control_data = dcd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q <= 8'h00;
            dcd_q <= 8'h00;
            cnt_q <= '0;
        end else begin
            rsp_q <= rsp_nx;
            if ((state == GET_ARG) && accept) begin
                dcd_q <= bus.cmd_data;
            end
            cnt_q <= (state == LAUNCH) ? cnt_inc : '0;
        end
    end
endmodule

// File: doc/dcr_host_ctrl.md
# dcr_host_ctrl

Host-side command sequencer that drives the GPU's device control register (DCR) write port and kernel launch handshake. It accepts a byte-oriented command stream from the host link, issues single-cycle DCR writes, and reads back the current thread count. It also runs the start/done launch protocol with a timeout. Every command returns exactly one response byte on a valid/ready stream. It sits between the host transport (UART/SPI bridge) and the GPU top level.

## Interface
- TIMEOUT, default 1024: maximum cycles spent in LAUNCH waiting for `done`. Must be ≥ 1.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  host command byte valid
- cmd_data  in  8  host command byte
- cmd_ready  out  1  block accepts `cmd_data` this cycle
- rsp_valid  out  1  response byte valid
- rsp_data  out  8  response byte
- rsp_ready  in  1  host consumes response
- device_control_write_enable  out  1  DCR write strobe
- device_control_data  out  8  DCR write data
- thread_count  in  8  current DCR contents (readback)
- start  out  1  kernel start, level
- done  in  1  kernel complete

## Operation
- Opcodes:
  - 0x01 WRITE: takes one argument byte.
  - 0x02 READ: no argument.
  - 0x03 LAUNCH: no argument.
  - Any other opcode: response 0xEF. No other effect.
- States: IDLE, GET_ARG, WRITE, LAUNCH, RESP.
  - IDLE → GET_ARG on accepting 0x01.
  - IDLE → RESP on accepting 0x02, on accepting an unknown opcode, or on accepting 0x03 when `thread_count` = 0 (response 0xE1).
  - IDLE → LAUNCH on accepting 0x03 when `thread_count` ≠ 0.
  - GET_ARG → WRITE on accepting the argument.
  - WRITE → RESP (response 0x00).
  - LAUNCH → RESP on `done` (response 0x00) or on timeout (response 0xE2).
  - RESP → IDLE when `rsp_valid && rsp_ready`.
- `cmd_ready` = 1 exactly in IDLE and GET_ARG; it is decoded from state. A byte is accepted when `cmd_valid && cmd_ready`.
- `device_control_data` is a register loaded with the argument on acceptance. It holds that value until the next WRITE.
- READ response = `thread_count`, sampled on the clock edge that accepts the opcode.
- `start` = 1 exactly while in LAUNCH.
- Timeout counter:
  - Cleared on LAUNCH entry and incremented every LAUNCH cycle.
  - Width is $clog2(TIMEOUT+1).
  - Timeout fires when the count reaches TIMEOUT with `done` still 0.
- `done` sampled in the same cycle the timeout fires: `done` wins, response 0x00.
- `done` outside LAUNCH is ignored.
- `rsp_data` is stable while `rsp_valid` = 1 and `rsp_ready` = 0.

## Timing
- Reset values:
  - State IDLE, so `cmd_ready` = 1.
  - `rsp_valid` = 0, `rsp_data` = 0x00.
  - `device_control_write_enable` = 0, `device_control_data` = 0x00.
  - `start` = 0, timeout counter = 0.
- WRITE: opcode accepted at cycle T, argument accepted at T2 ≥ T+1.
  - T2+1: `device_control_write_enable` = 1 for exactly one cycle, with `device_control_data` = argument.
  - T2+2: `rsp_valid` = 1, `rsp_data` = 0x00.
  - The DCR updates at the end of T2+1, so a following READ returns the new value.
- READ: opcode accepted at T → `rsp_valid` at T+1.
- LAUNCH:
  - Opcode accepted at T → `start` = 1 from T+1.
  - If `done` = 1 at cycle D: `start` = 0 and `rsp_valid` = 1 from D+1.
  - Without `done`: `start` is high for cycles T+1..T+TIMEOUT; `start` = 0 and response 0xE2 from T+TIMEOUT+1.
- Error response (0xE1/0xEF): `rsp_valid` at T+1.
- At most one command is in flight. No opcode is accepted from the cycle after acceptance until the response handshake completes.
- Back-to-back: a new opcode can be accepted in the cycle after the `rsp_valid && rsp_ready` cycle.
- Reset mid-operation, from the next edge:
  - Any pending response is discarded.
  - `start` and `device_control_write_enable` drop to 0.
  - The argument byte of a partial WRITE is discarded.

## Test plan
- Reset, then stream 0x01, 0x08 with `rsp_ready` = 1 → one-cycle write strobe with data 0x08, then response 0x00. A following 0x02 (with DCR model attached) → response 0x08.
- 0x03 with `thread_count` = 4 and `done` asserted 20 cycles after `start` → `start` high for exactly 20 cycles, then response 0x00. 0x03 with `thread_count` = 0 → response 0xE1 and `start` never asserts.
- TIMEOUT = 16, 0x03 with `done` held 0 → `start` high for exactly 16 cycles, then response 0xE2. Repeat with `done` = 1 on the 16th cycle → response 0x00.
- Opcode 0x7F → response 0xEF. Hold `rsp_ready` = 0 for 5 cycles → `rsp_valid`/`rsp_data` held stable and `cmd_ready` = 0 throughout.
- Assert reset during GET_ARG and again mid-LAUNCH → `start` = 0 and no response emitted. Next 0x02 → response equals the pre-reset DCR value (no stray write).
- Randomised `cmd_valid`/`rsp_ready` gaps over 200 commands → response count equals command count and each response matches a scoreboard.
